keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_TICKS, default 100000, clk cycles each column is driven; legal range >= 4.
REQ-002 Parameter DEBOUNCE_SWEEPS, default 4, consecutive identical full sweeps needed to accept a press or release; legal range >= 1.
REQ-003 Parameter REPEAT_SWEEPS, default 50, sweeps between auto-repeat pulses; used only when KEYPAD_REPEAT_EN is defined.
REQ-004 Port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port row, input, 4, keypad row lines, active-low, asynchronous to clk.
REQ-007 Port col, output, 4, keypad column drive, active-low, one-hot-low.
REQ-008 Port key_code, output, 4, hex value of the accepted key; holds until the next accepted key.
REQ-009 Port key_valid, output, 1, one-cycle pulse when a key is accepted (or repeated).
REQ-010 Port key_held, output, 1, level, high while an accepted key remains pressed.

Function
REQ-011 row SHALL pass through a 2-FF synchronizer before any use.
REQ-012 Column scan SHALL cycle col = 1110, 1101, 1011, 0111 (col index 0..3), each for SCAN_TICKS cycles, then wrap to 1110; one wrap = one sweep.
REQ-013 Synchronized row SHALL be sampled on the last cycle of each column window only.
REQ-014 Sweep result: NONE (no row low in any column), SINGLE (exactly one row/column intersection low), MULTI (more than one); MULTI SHALL be treated as NONE for release counting and SHALL never be accepted.
REQ-015 Key map (row r, col c): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: 0,F,E,D for c=0..3.
REQ-016 FSM states IDLE, PRESS, HELD, RELEASE, evaluated once per sweep end.
REQ-017 IDLE: SINGLE -> PRESS with candidate stored, count=1; else stay.
REQ-018 PRESS: SINGLE same candidate -> count+1; on count reaching DEBOUNCE_SWEEPS -> HELD, key_code=candidate, key_valid pulses next cycle, key_held=1; SINGLE different key -> restart count=1 with new candidate; NONE/MULTI -> IDLE.
REQ-019 HELD: same key -> stay; NONE/MULTI/different key -> RELEASE, count=1.
REQ-020 RELEASE: NONE/MULTI -> count+1, on reaching DEBOUNCE_SWEEPS -> IDLE and key_held=0; same key reappears -> HELD, no new pulse.
REQ-021 A different key pressed while in HELD SHALL NOT be accepted until release completes and a new PRESS debounce finishes.
REQ-022 key_valid SHALL never be high for two consecutive cycles.

Reset
REQ-023 Reset asserted SHALL immediately force col=1110, key_code=0, key_valid=0, key_held=0, state IDLE, counters and synchronizer to idle (row sync = 1111).
REQ-024 Reset mid-debounce or mid-hold SHALL discard the candidate; no key_valid pulse SHALL follow reset release without a full new debounce.

Configuration
REQ-025 Macro KEYPAD_REPEAT_EN defined: in HELD, after REPEAT_SWEEPS sweeps of the same key, key_valid SHALL pulse again and every REPEAT_SWEEPS sweeps thereafter while held.
REQ-026 Macro KEYPAD_REPEAT_EN undefined: exactly one key_valid pulse per accepted press; repeat counter absent.

Verification (SCAN_TICKS=4, DEBOUNCE_SWEEPS=3, REPEAT_SWEEPS=5; sweep = 16 cycles)
REQ-027 Reset then idle rows 1111 -> col sequence 1110,1101,1011,0111 each 4 cycles, key_valid never high.
REQ-028 Key "5" (row1 low when col=1101) held 4 sweeps -> exactly one key_valid pulse after 3rd sweep end, key_code=5, key_held=1; release 3 sweeps -> key_held=0.
REQ-029 Key "D" pressed 2 sweeps, released, pressed again -> no pulse until 3 consecutive sweeps; then key_code=D.
REQ-030 Keys "1" and "9" both held 5 sweeps -> no key_valid, key_code unchanged.
REQ-031 Reset asserted during 2nd PRESS sweep of "A" -> outputs at reset values immediately; after release, "A" held 3 sweeps -> single pulse, key_code=A.
REQ-032 With KEYPAD_REPEAT_EN, "3" held 13 sweeps -> pulses at end of sweeps 3, 8, 13; without macro -> pulse at sweep 3 only.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix scan with per-sweep debounce.
// Define KEYPAD_REPEAT_EN to enable auto-repeat pulses while a key is held.
module keypad_scanner #(
  parameter int SCAN_TICKS      = 100000,
  parameter int DEBOUNCE_SWEEPS = 4,
  parameter int REPEAT_SWEEPS   = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int TW = $clog2(SCAN_TICKS);
  localparam int DW = $clog2(DEBOUNCE_SWEEPS + 1);
  localparam logic [TW-1:0] T_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_SWEEPS);

  if (SCAN_TICKS < 4) begin : g_bad_scan
    $error("SCAN_TICKS must be >= 4");
  end
  if (DEBOUNCE_SWEEPS < 1) begin : g_bad_deb
    $error("DEBOUNCE_SWEEPS must be >= 1");
  end
  if (REPEAT_SWEEPS < 1) begin : g_bad_rep
    $error("REPEAT_SWEEPS must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    HELD,
    RELEASE
  } state_t;

  logic [3:0]    row_s1;
  logic [3:0]    row_s2;
  logic [TW-1:0] tick;
  logic [1:0]    col_idx;
  logic          win_end;
  logic          sweep_end;

  logic [1:0]    hits;
  logic [3:0]    hit_code;
  logic [3:0]    lows;
  logic [2:0]    col_hits;
  logic [2:0]    hit_sum;
  logic [1:0]    row_sel;
  logic [1:0]    new_hits;
  logic [3:0]    new_code;
  logic          single;
  logic          same;

  state_t        state;
  logic [3:0]    cand;
  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_nx;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SWEEPS + 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_SWEEPS);
  logic [RW-1:0] rep;
  logic [RW-1:0] rep_nx;
  assign rep_nx = rep + RW'(1);
`endif

  function automatic logic [3:0] code_of(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] k;
    unique case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'h0;
      4'hD: k = 4'hF;
      4'hE: k = 4'hE;
      4'hF: k = 4'hD;
    endcase
    return k;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  assign win_end   = (tick == T_LAST);
  assign sweep_end = win_end && (col_idx == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick    <= '0;
      col_idx <= 2'd0;
      col     <= 4'b1110;
    end else if (win_end) begin
      tick    <= '0;
      col_idx <= col_idx + 2'd1;
      col     <= {col[2:0], col[3]};
    end else begin
      tick <= tick + TW'(1);
    end
  end

  // hits saturates at 2: anything beyond one intersection is MULTI
  always_comb begin
    lows     = ~row_s2;
    col_hits = 3'(lows[0]) + 3'(lows[1]) + 3'(lows[2]) + 3'(lows[3]);
    row_sel  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (lows[i]) row_sel = 2'(i);
    end
    hit_sum  = {1'b0, hits} + col_hits;
    new_hits = (hit_sum > 3'd1) ? 2'd2 : hit_sum[1:0];
    new_code = (col_hits == 3'd1) ? code_of(row_sel, col_idx) : hit_code;
  end

  assign single = (new_hits == 2'd1);
  assign same   = single && (new_code == key_code);
  assign cnt_nx = cnt + DW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hits     <= 2'd0;
      hit_code <= 4'h0;
    end else if (sweep_end) begin
      hits     <= 2'd0;
      hit_code <= 4'h0;
    end else if (win_end) begin
      hits     <= new_hits;
      hit_code <= new_code;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cand      <= 4'h0;
      cnt       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep       <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (sweep_end) begin
        unique case (state)
          IDLE: begin
            if (single) begin
              cand <= new_code;
              cnt  <= DW'(1);
              if (DEBOUNCE_SWEEPS == 1) begin
                state     <= HELD;
                key_code  <= new_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                rep       <= '0;
`endif
              end else begin
                state <= PRESS;
              end
            end
          end
          PRESS: begin
            if (!single) begin
              state <= IDLE;
            end else if (new_code != cand) begin
              cand <= new_code;
              cnt  <= DW'(1);
            end else if (cnt_nx == D_LAST) begin
              state     <= HELD;
              key_code  <= cand;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rep       <= '0;
`endif
            end else begin
              cnt <= cnt_nx;
            end
          end
          HELD: begin
            if (!same) begin
              if (DEBOUNCE_SWEEPS == 1) begin
                state    <= IDLE;
                key_held <= 1'b0;
              end else begin
                state <= RELEASE;
                cnt   <= DW'(1);
              end
            end
`ifdef KEYPAD_REPEAT_EN
            else if (rep_nx == R_LAST) begin
              key_valid <= 1'b1;
              rep       <= '0;
            end else begin
              rep <= rep_nx;
            end
`endif
          end
          RELEASE: begin
            if (same) begin
              state <= HELD;
`ifdef KEYPAD_REPEAT_EN
              rep   <= '0;
`endif
            end else if (cnt_nx == D_LAST) begin
              state    <= IDLE;
              key_held <= 1'b0;
            end else begin
              cnt <= cnt_nx;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: random keypad patterns vs sweep-level reference model.
// Expected key_valid events are queued and checked by an independent monitor.
module tb_keypad_scanner;

  localparam int ST = 4;
  localparam int DB = 3;
  localparam int RP = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  keypad_scanner #(
    .SCAN_TICKS     (ST),
    .DEBOUNCE_SWEEPS(DB),
    .REPEAT_SWEEPS  (RP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] pressed = '0;
  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

  // physical keypad: a pressed key shorts its row to its driven column
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  int exp_q[$];
  int held = 0;
  int held_key = 0;
  int cand = 0;
  int run = 0;
  int rel = 0;
  int rep = 0;
  int last_code = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sweep_code(input logic [15:0] p);
    int idx;
    if ($countones(p) == 0) return -1;
    if ($countones(p) > 1) return -2;
    idx = 0;
    for (int i = 0; i < 16; i++) if (p[i]) idx = i;
    return keymap[idx];
  endfunction

  task automatic model_reset();
    held = 0;
    run = 0;
    rel = 0;
    rep = 0;
    last_code = 0;
  endtask

  task automatic model_sweep(input logic [15:0] p);
    int s;
    s = sweep_code(p);
    if (held == 0) begin
      if (s >= 0) begin
        if (run > 0 && s == cand) run++;
        else begin
          cand = s;
          run = 1;
        end
        if (run == DB) begin
          held = 1;
          held_key = s;
          rel = 0;
          rep = 0;
          last_code = s;
          exp_q.push_back(s);
        end
      end else begin
        run = 0;
      end
    end else if (s == held_key) begin
      if (rel > 0) begin
        rel = 0;
        rep = 0;
      end else begin
        rep++;
`ifdef KEYPAD_REPEAT_EN
        if (rep == RP) begin
          exp_q.push_back(s);
          rep = 0;
        end
`endif
      end
    end else begin
      rel++;
      if (rel == DB) begin
        held = 0;
        run = 0;
      end
    end
  endtask

  task automatic next_sweep();
    logic [3:0] last;
    bit found;
    last = col;
    found = 0;
    for (int n = 0; n < 4 * ST + 8 && !found; n++) begin
      @(negedge clk);
      if (last == 4'b0111 && col == 4'b1110) found = 1;
      last = col;
    end
    if (!found) begin
      miscompares++;
      $display("FAIL sweep_wrap: col never wrapped, col=%b", col);
    end
  endtask

  task automatic sweep(input logic [15:0] p);
    next_sweep();
    chk("key_held", int'(key_held), held);
    chk("key_code", int'(key_code), last_code);
    pressed = p;
    model_sweep(p);
  endtask

  task automatic hold(input logic [15:0] p, input int n);
    for (int i = 0; i < n; i++) sweep(p);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_col"}, int'(col), 4'b1110);
    chk({tag, "_code"}, int'(key_code), 0);
    chk({tag, "_valid"}, int'(key_valid), 0);
    chk({tag, "_held"}, int'(key_held), 0);
  endtask

  // monitor: every key_valid pulse must match the oldest expected key
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_v <= 1'b0;
    end else begin
      if (key_valid && prev_v) begin
        miscompares++;
        $display("FAIL valid_twice: key_valid high two cycles at %0t", $time);
      end
      if (key_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL pulse: unexpected key_valid, key_code=%h", key_code);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (int'(key_code) != e) begin
            miscompares++;
            $display("FAIL pulse_code: got %h expected %h", key_code, e);
          end
        end
      end
      prev_v <= key_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p;
    int k;
    int n;
    reset = 1'b1;
    pressed = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b0;

    // idle scan: column order and window length
    sweep('0);
    for (int i = 0; i < 4 * ST; i++) begin
      logic [3:0] ec;
      ec = ~(4'b0001 << (i / ST));
      chk("col_seq", int'(col), int'(ec));
      if (i < 4 * ST - 1) @(negedge clk);
    end

    // key 5: row1/col1
    hold(16'h0020, 4);
    hold('0, 4);

    // key D: short press, gap, then full debounce
    hold(16'h8000, 2);
    hold('0, 1);
    hold(16'h8000, 3);
    hold('0, 4);

    // keys 1 and 9 together never accepted
    hold(16'h0401, 5);
    hold('0, 2);

    // reset in the middle of the second PRESS sweep of A
    sweep(16'h0008);
    repeat (4 * ST + 2 * ST) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    repeat (2) @(negedge clk);
    pressed = '0;
    reset = 1'b0;
    hold(16'h0008, 3);
    hold('0, 4);

    // key 3 held long: repeat behaviour depends on build
    hold(16'h0004, 13);
    hold('0, 4);

    for (int seg = 0; seg < 40; seg++) begin
      k = $urandom_range(0, 9);
      p = '0;
      if (k >= 3) p[$urandom_range(0, 15)] = 1'b1;
      if (k >= 8) p[$urandom_range(0, 15)] = 1'b1;
      n = $urandom_range(1, 6);
      hold(p, n);
    end
    hold('0, 4);
    next_sweep();
    repeat (4) @(negedge clk);
    chk("pending_pulses", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
